// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words for instruction memory.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_start,
   input  logic [7:0]        i_rxData,
   input  logic              i_rxValid,
   output logic              o_rxReady,
   output logic              o_imemWriteEn,
   output logic [ADDR_W-1:0] o_imemWriteAddress,
   output logic [31:0]       o_imemWriteData,
   output logic              o_coreHold,
   output logic              o_done,
   output logic              o_error,
   output logic [15:0]       o_wordCount
);

   localparam int unsigned MAX_WORDS = 2**ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CSUM,
`else
      FLUSH,
`endif
      DONE,
      ERROR
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [15:0]       lenReg;
   logic [1:0]        byteIdx;
   logic [23:0]       wordBuf;
   logic [ADDR_W-1:0] addrCnt;
   logic              accept;
   logic              startOk;
   logic              lastWord;
   logic [15:0]       lenIn;
   logic              lenTooBig;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   assign accept    = i_rxValid & o_rxReady;
   assign startOk   = i_start & ((state == IDLE) | (state == DONE) | (state == ERROR));
   assign lastWord  = (o_wordCount + 16'd1) == lenReg;
   assign lenIn     = {i_rxData, lenReg[7:0]};
   assign lenTooBig = {16'd0, lenIn} > MAX_WORDS;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE, DONE, ERROR: if (i_start) stateNext = LEN0;
         LEN0: if (accept) stateNext = LEN1;
         LEN1: if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (lenIn == '0)    stateNext = CSUM;
`else
            if (lenIn == '0)    stateNext = DONE;
`endif
            else if (lenTooBig) stateNext = ERROR;
            else                stateNext = DATA;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         DATA: if (accept && byteIdx == 2'd3 && lastWord) stateNext = CSUM;
         CSUM: if (accept) stateNext = (csum == i_rxData) ? DONE : ERROR;
`else
         // FLUSH covers the final write strobe so o_done trails it by one cycle.
         DATA: if (accept && byteIdx == 2'd3 && lastWord) stateNext = FLUSH;
         FLUSH: stateNext = DONE;
`endif
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      o_rxReady  = 1'b0;
      o_coreHold = 1'b1;
      o_done     = 1'b0;
      o_error    = 1'b0;
      case (state)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         LEN0, LEN1, DATA, CSUM: o_rxReady = 1'b1;
`else
         LEN0, LEN1, DATA: o_rxReady = 1'b1;
`endif
         DONE: begin
            o_coreHold = 1'b0;
            o_done     = 1'b1;
         end
         ERROR: o_error = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         lenReg             <= '0;
         byteIdx            <= '0;
         wordBuf            <= '0;
         addrCnt            <= '0;
         o_wordCount        <= '0;
         o_imemWriteEn      <= 1'b0;
         o_imemWriteAddress <= '0;
         o_imemWriteData    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum               <= '0;
`endif
      end else begin
         o_imemWriteEn <= 1'b0;
         if (startOk) begin
            byteIdx     <= '0;
            addrCnt     <= '0;
            o_wordCount <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
         end
         if (state == LEN0 && accept) lenReg[7:0]  <= i_rxData;
         if (state == LEN1 && accept) lenReg[15:8] <= i_rxData;
         if (state == DATA && accept) begin
            byteIdx <= byteIdx + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum    <= csum ^ i_rxData;
`endif
            case (byteIdx)
               2'd0: wordBuf[7:0]   <= i_rxData;
               2'd1: wordBuf[15:8]  <= i_rxData;
               2'd2: wordBuf[23:16] <= i_rxData;
               default: begin
                  o_imemWriteEn      <= 1'b1;
                  o_imemWriteAddress <= addrCnt;
                  o_imemWriteData    <= {i_rxData, wordBuf};
                  addrCnt            <= addrCnt + 1'b1;
                  o_wordCount        <= o_wordCount + 16'd1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized frames against a byte-queue model.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  rxData = '0;
   logic        rxValid = 1'b0;
   logic        rxReady;
   logic        wrEn;
   logic [7:0]  wrAddr;
   logic [31:0] wrData;
   logic        coreHold;
   logic        done;
   logic        error;
   logic [15:0] wordCount;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned wrCount = 0;
   int unsigned run = 0;
   int unsigned maxRun = 0;
   logic [7:0]  dq[$];

   program_loader #(.ADDR_W(8)) dut (
      .i_clk(clk), .i_arst(arst), .i_start(start), .i_rxData(rxData), .i_rxValid(rxValid),
      .o_rxReady(rxReady), .o_imemWriteEn(wrEn), .o_imemWriteAddress(wrAddr),
      .o_imemWriteData(wrData), .o_coreHold(coreHold), .o_done(done), .o_error(error),
      .o_wordCount(wordCount)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wrEn === 1'b1) begin
         wrCount++;
         run++;
         if (run > maxRun) maxRun = run;
      end else run = 0;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int unsigned t = 0;
      rxData  = b;
      rxValid = 1'b1;
      while (rxReady !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      total++;
      if (rxReady !== 1'b1) begin
         bad++;
         $display("FAIL byte_accept: rxReady=%b required=1", rxReady);
      end
      @(negedge clk);
      rxValid = 1'b0;
   endtask

   task automatic gap(input int unsigned n, input bit withStart);
      for (int unsigned i = 0; i < n; i++) begin
         if (withStart) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         total++;
         if (rxReady !== 1'b1) begin
            bad++;
            $display("FAIL ready_in_gap: rxReady=%b required=1", rxReady);
         end
      end
   endtask

   function automatic int unsigned gap_len(input int mode);
      if (mode == 0) return 0;
      if (mode == 2) return $urandom_range(0, 3);
      return 1;
   endfunction

   task automatic fill(input int unsigned n);
      dq.delete();
      for (int unsigned i = 0; i < 4 * n; i++) dq.push_back(8'($urandom));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (coreHold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || wordCount !== 16'd0 || rxReady !== 1'b1) begin
         bad++;
         $display("FAIL start_entry: hold=%b done=%b err=%b cnt=%0d rdy=%b required 1 0 0 0 1",
                  coreHold, done, error, wordCount, rxReady);
      end
   endtask

   // mode: 0 back-to-back, 1 alternate idle cycles, 2 random gaps, 3 idle cycles carrying i_start
   task automatic run_frame(input logic [15:0] n, input int mode);
      int unsigned w0;
      int unsigned t;
      logic [7:0]  cs;
      logic [31:0] expWord;
      cs = '0;
      pulse_start();
      w0 = wrCount;
      maxRun = 0;
      send_byte(n[7:0]);
      gap(gap_len(mode), mode == 3);
      send_byte(n[15:8]);
      if (n > 16'd256) begin
         total++;
         if (error !== 1'b1 || rxReady !== 1'b0 || coreHold !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL overlen_error: err=%b rdy=%b hold=%b done=%b required 1 0 1 0",
                     error, rxReady, coreHold, done);
         end
         rxValid = 1'b1;
         rxData  = 8'h5A;
         repeat (4) @(negedge clk);
         rxValid = 1'b0;
         total++;
         if (wrCount != w0 || error !== 1'b1 || coreHold !== 1'b1) begin
            bad++;
            $display("FAIL overlen_stays: writes=%0d err=%b hold=%b required 0 1 1",
                     wrCount - w0, error, coreHold);
         end
         return;
      end
      for (int unsigned k = 0; k < n; k++) begin
         for (int unsigned j = 0; j < 4; j++) begin
            if (k != 0 || j != 0) gap(gap_len(mode), mode == 3);
            send_byte(dq[4*k+j]);
            cs ^= dq[4*k+j];
         end
         expWord = {dq[4*k+3], dq[4*k+2], dq[4*k+1], dq[4*k]};
         total++;
         if (wrEn !== 1'b1 || wrAddr !== 8'(k) || wrData !== expWord) begin
            bad++;
            $display("FAIL write_word%0d: en=%b addr=%0d data=%h required 1 %0d %h",
                     k, wrEn, wrAddr, wrData, k, expWord);
         end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
         if (k == 32'(n) - 1) begin
            total++;
            if (done !== 1'b0) begin
               bad++;
               $display("FAIL done_early: done=%b required=0", done);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b1 || coreHold !== 1'b0 || wrEn !== 1'b0) begin
               bad++;
               $display("FAIL done_latency: done=%b hold=%b en=%b required 1 0 0", done, coreHold, wrEn);
            end
         end
`endif
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(cs);
`endif
      t = 0;
      while (done !== 1'b1 && error !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      total++;
      if (done !== 1'b1 || error !== 1'b0 || coreHold !== 1'b0 || wordCount !== n ||
          wrCount - w0 != 32'(n) || (n != 0 && maxRun != 1)) begin
         bad++;
         $display("FAIL frame_end n=%0d: done=%b err=%b hold=%b cnt=%0d writes=%0d run=%0d required 1 0 0 %0d %0d 1",
                  n, done, error, coreHold, wordCount, wrCount - w0, maxRun, n, n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if (coreHold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || rxReady !== 1'b0 ||
          wrEn !== 1'b0 || wordCount !== 16'd0 || wrAddr !== 8'd0 || wrData !== 32'd0) begin
         bad++;
         $display("FAIL reset_state: hold=%b done=%b err=%b rdy=%b en=%b cnt=%0d required 1 0 0 0 0 0",
                  coreHold, done, error, rxReady, wrEn, wordCount);
      end
      arst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (coreHold !== 1'b1 || done !== 1'b0 || rxReady !== 1'b0) begin
         bad++;
         $display("FAIL idle_state: hold=%b done=%b rdy=%b required 1 0 0", coreHold, done, rxReady);
      end
   endtask

   task automatic test_basic();
      dq = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      run_frame(16'd2, 0);
   endtask

   task automatic test_gaps();
      dq = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
      run_frame(16'd2, 1);
   endtask

   task automatic test_boundary();
      dq.delete();
      run_frame(16'h0101, 0);
      fill(0);
      run_frame(16'd0, 0);
      fill(256);
      run_frame(16'd256, 0);
   endtask

   task automatic test_midreset();
      fill(2);
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      for (int unsigned i = 0; i < 6; i++) send_byte(dq[i]);
      #2 arst = 1'b1;
      #1;
      total++;
      if (coreHold !== 1'b1 || wordCount !== 16'd0 || rxReady !== 1'b0 || wrEn !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL midreset: hold=%b cnt=%0d rdy=%b en=%b done=%b required 1 0 0 0 0",
                  coreHold, wordCount, rxReady, wrEn, done);
      end
      @(negedge clk);
      arst = 1'b0;
      @(negedge clk);
      fill(2);
      run_frame(16'd2, 0);
   endtask

   task automatic test_start_ignored();
      fill(3);
      run_frame(16'd3, 3);
      fill(1);
      run_frame(16'd1, 0);
   endtask

   task automatic test_random();
      for (int unsigned f = 0; f < 8; f++) begin
         fill($urandom_range(1, 8));
         run_frame(16'(dq.size() / 4), 2);
      end
   endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] frame[7];
      int unsigned w0;
      frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      for (int unsigned pass = 0; pass < 2; pass++) begin
         if (pass == 1) frame[6] = 8'h23;
         pulse_start();
         w0 = wrCount;
         for (int unsigned i = 0; i < 7; i++) send_byte(frame[i]);
         @(negedge clk);
         total++;
         if (pass == 0 && (done !== 1'b1 || error !== 1'b0 || coreHold !== 1'b0 || wrCount - w0 != 1)) begin
            bad++;
            $display("FAIL csum_match: done=%b err=%b hold=%b writes=%0d required 1 0 0 1",
                     done, error, coreHold, wrCount - w0);
         end else if (pass == 1 && (done !== 1'b0 || error !== 1'b1 || coreHold !== 1'b1)) begin
            bad++;
            $display("FAIL csum_mismatch: done=%b err=%b hold=%b required 0 1 1", done, error, coreHold);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_boundary();
      test_midreset();
      test_start_ignored();
      test_random();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
